cla_add64_seq: RTL and testbench
================================

// Module: cla_add64_seq
// PURPOSE
//   Handshaked, multi-cycle 64-bit adder: the responder end of the operand/result
//   interface that our adder benches drive. Operands arrive on a valid/ready request
//   channel. Internally the adder sums one CHUNK_W-bit slice per cycle using 4-bit CLA
//   groups, carrying between slices. It returns {cout,sum} on a valid/ready response
//   channel. It replaces the purely combinational adder where timing needs a short path.
// PARAMETERS
//   WIDTH    64  operand/sum width; must be a multiple of CHUNK_W
//   CHUNK_W  16  bits added per cycle; must be a multiple of 4 (4-bit CLA groups)
// PORTS
//   CLK        in   1        clock, all state updates on posedge
//   reset      in   1        synchronous, active-high reset
//   in_valid   in   1        request: in_a/in_b/cin are valid
//   in_ready   out  1        responder can accept a request (1 only in IDLE)
//   in_a       in   WIDTH    operand A
//   in_b       in   WIDTH    operand B
//   cin        in   1        carry-in
//   out_valid  out  1        result valid (1 only in DONE)
//   out_ready  in   1        consumer accepts result
//   sum        out  WIDTH    (in_a + in_b + cin) mod 2^WIDTH
//   cout       out  1        carry out of bit WIDTH-1
// BEHAVIOUR
//   - Reset (sync, posedge CLK with reset=1): state=IDLE, in_ready=1, out_valid=0,
//     sum=0, cout=0, chunk index=0, operand regs=0. Overrides every other input.
//   - FSM, N = WIDTH/CHUNK_W (default 4):
//     IDLE: in_ready=1. If in_valid at a posedge: latch in_a, in_b, cin into internal
//       regs, clear the chunk index, go to ADD. Inputs are ignored in every other state.
//     ADD: each posedge adds slice k (bits k*CHUNK_W +: CHUNK_W) of the latched operands
//       plus the running carry. Slice 0 uses the latched cin. Slice k writes sum[k-th slice].
//       Its carry-out becomes the next running carry. After slice N-1, cout = final
//       carry and the state goes to DONE.
//     DONE: out_valid=1. sum and cout are held stable until a posedge with out_ready=1,
//       then the state goes to IDLE. sum and cout keep their last value in IDLE.
//   - Latency: accept at posedge T; out_valid is first high after posedge T+N.
//     Minimum spacing between accepts is N+2 cycles.
//   - Within a slice, carries are generated by 4-bit CLA groups (g=a&b, p=a^b,
//     c[i+1]=g[i]|p[i]&c[i] expanded per group) and rippled between groups.
//   - Boundaries:
//     - out_ready=1 in DONE together with in_valid=1: the request is NOT accepted that
//       cycle, because in_ready=0. It is accepted on the next posedge in IDLE if still valid.
//     - out_ready high before DONE has no effect.
//     - Changes on in_a/in_b/cin after accept do not affect the result.
//     - Reset during ADD or DONE abandons the operation. The result is never presented.
//     - WIDTH/CHUNK_W or CHUNK_W%4 not integral: elaboration error via generate check.
// TESTING
//   1. reset=1 for 2 cycles -> in_ready=1, out_valid=0, sum=0, cout=0.
//   2. in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=0, cin=1 -> sum=0, cout=1, with out_valid
//      first high exactly 4 cycles after the accept edge.
//   3. in_a=in_b=64'h8000_0000_0000_0000, cin=0 -> sum=0, cout=1.
//      Then in_a=64'h0000_0000_0000_FFFF, in_b=1, cin=0 -> sum=64'h1_0000, cout=0
//      (exercises the carry across a slice boundary).
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and
//      changing operands -> sum/cout stable, in_ready=0, no second accept.
//      Then out_ready=1 -> IDLE next cycle, the new request is accepted the cycle after.
//   5. Assert reset at the 2nd ADD cycle -> next cycle IDLE, out_valid=0, sum=0.
//      A following request computes correctly.
//   6. 1000 random requests ({$random} products, random cin, random out_ready stalls)
//      -> every {cout,sum} equals the 65-bit in_a+in_b+cin computed by the bench model.

Source files
------------

// File: rtl/cla_add64_seq_if.sv
// Operand/result channel for the sequential CLA adder: a valid/ready request
// channel carrying a, b, cin and a valid/ready response channel carrying {cout,sum}.
interface cla_add64_seq_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport slave (
      input  in_valid, in_a, in_b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

   modport master (
      output in_valid, in_a, in_b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/cla_add64_seq.sv
// Handshaked multi-cycle adder: sums one CHUNK_W slice per cycle with 4-bit CLA
// groups, rippling the carry between groups and between slices.
module cla_add64_seq #(
   parameter int WIDTH   = 64,
   parameter int CHUNK_W = 16
) (
   input  logic           CLK,
   input  logic           reset,
   cla_add64_seq_if.slave bus
);
   localparam int N     = WIDTH / CHUNK_W;
   localparam int NG    = CHUNK_W / 4;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % CHUNK_W) != 0 || (CHUNK_W % 4) != 0 || CHUNK_W < 4 || WIDTH < CHUNK_W) begin : g_bad_params
      $error("cla_add64_seq: WIDTH must be a multiple of CHUNK_W, CHUNK_W a multiple of 4");
   end

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [IDX_W-1:0]   r_idx;

   logic [CHUNK_W-1:0] w_sa;
   logic [CHUNK_W-1:0] w_sb;
   logic [CHUNK_W-1:0] w_ss;
   logic [NG:0]        w_gc;
   logic [WIDTH-1:0]   w_sum_next;

   // Operand registers shift down one slice per ADD cycle, so the live slice is always at the bottom.
   assign w_sa    = r_a[CHUNK_W-1:0];
   assign w_sb    = r_b[CHUNK_W-1:0];
   assign w_gc[0] = r_carry;

   for (genvar gi = 0; gi < NG; gi++) begin : g_cla
      logic [3:0] w_g;
      logic [3:0] w_p;
      logic [3:0] w_c;
      assign w_g = w_sa[gi*4 +: 4] & w_sb[gi*4 +: 4];
      assign w_p = w_sa[gi*4 +: 4] ^ w_sb[gi*4 +: 4];
      assign w_c[0] = w_gc[gi];
      assign w_c[1] = w_g[0] | (w_p[0] & w_gc[gi]);
      assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_gc[gi]);
      assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & w_gc[gi]);
      assign w_gc[gi+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                        | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_gc[gi]);
      assign w_ss[gi*4 +: 4] = w_p ^ w_c;
   end

   always_comb begin
      w_sum_next = r_sum;
      for (int k = 0; k < N; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_sum_next[k*CHUNK_W +: CHUNK_W] = w_ss;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_idx       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a        <= bus.in_a;
                  r_b        <= bus.in_b;
                  r_carry    <= bus.cin;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ADD;
               end
            end
            ADD: begin
               r_sum   <= w_sum_next;
               r_a     <= r_a >> CHUNK_W;
               r_b     <= r_b >> CHUNK_W;
               r_carry <= w_gc[NG];
               r_idx   <= r_idx + 1'b1;
               if (r_idx == IDX_W'(N - 1)) begin
                  r_cout      <= w_gc[NG];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
endmodule

// File: tb/tb_cla_add64_seq.sv
// Bench for cla_add64_seq: a transaction-level model predicts handshake state and
// {cout,sum}; directed cases pin the model with literal results, then random traffic.
module tb_cla_add64_seq;
   localparam int W = 64;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cla_add64_seq_if #(.WIDTH(W)) ifc();

   cla_add64_seq #(.WIDTH(W), .CHUNK_W(16)) dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (ifc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction model: 0 = waiting for a request, 1 = computing, 2 = holding a result.
   int          m_phase = 0;
   int          m_left  = 0;
   logic [64:0] m_pend  = '0;
   logic [64:0] m_out   = '0;
   bit          m_en    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_out   = '0;
      end else begin
         case (m_phase)
            0: if (ifc.in_valid) begin
                  m_pend  = {1'b0, ifc.in_a} + {1'b0, ifc.in_b} + 65'(ifc.cin);
                  m_left  = N;
                  m_phase = 1;
               end
            1: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_out   = m_pend;
                     m_phase = 2;
                  end
               end
            default: if (ifc.out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_en) begin
         chk("in_ready", 65'(ifc.in_ready), 65'(m_phase == 0));
         chk("out_valid", 65'(ifc.out_valid), 65'(m_phase == 2));
         if (m_phase != 1) chk("result", {ifc.cout, ifc.sum}, m_out);
      end
   end

   function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + 65'(c);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting posedge.
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c);
      ifc.in_a     = a;
      ifc.in_b     = b;
      ifc.cin      = c;
      ifc.in_valid = 1'b1;
      for (int i = 0; i < 50 && !ifc.in_ready; i++) @(negedge clk);
      chk("accept_ready", 65'(ifc.in_ready), 65'd1);
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_a     = rnd64();
      ifc.in_b     = rnd64();
      ifc.cin      = 1'($urandom);
   endtask

   task automatic wait_done(input bit rnd, output int lat);
      bit ok;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ifc.out_valid) begin
            ok = 1'b1;
            break;
         end
         lat++;
         if (rnd) begin
            ifc.in_valid  = 1'($urandom);
            ifc.in_a      = rnd64();
            ifc.out_ready = 1'($urandom);
         end
         @(negedge clk);
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      chk("done_timeout", 65'(ok), 65'd1);
   endtask

   task automatic finish_op(input int stall);
      ifc.out_ready = 1'b0;
      repeat (stall) @(negedge clk);
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
   endtask

   task automatic op_literal(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic c, input logic [64:0] exp);
      int lat;
      send(a, b, c);
      wait_done(1'b0, lat);
      chk({name, "_lat"}, 65'(lat), 65'(N));
      chk({name, "_dut"}, {ifc.cout, ifc.sum}, exp);
      chk({name, "_model"}, m_out, exp);
      $display("op %s a=%h b=%h cin=%0d -> cout=%0d sum=%h", name, a, b, c, ifc.cout, ifc.sum);
      finish_op(0);
   endtask

   initial begin
      int          lat;
      logic [63:0] a, b, a2, b2;
      logic        c, c2;
      logic [64:0] held;

      ifc.in_valid  = 1'b0;
      ifc.in_a      = '0;
      ifc.in_b      = '0;
      ifc.cin       = 1'b0;
      ifc.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 65'(ifc.in_ready), 65'd1);
      chk("rst_out_valid", 65'(ifc.out_valid), 65'd0);
      chk("rst_result", {ifc.cout, ifc.sum}, 65'd0);
      rst  = 1'b0;
      m_en = 1'b1;
      @(negedge clk);

      op_literal("all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
      op_literal("msb_pair", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'h0});
      op_literal("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 65'h1_0000);

      // Backpressure: result must hold while new requests are presented and refused.
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3210;
      send(a, b, 1'b1);
      wait_done(1'b0, lat);
      held = {1'b1, 64'h0};
      chk("bp_first", {ifc.cout, ifc.sum}, held);
      for (int i = 0; i < 10; i++) begin
         ifc.in_valid = 1'b1;
         ifc.in_a     = rnd64();
         ifc.in_b     = rnd64();
         ifc.cin      = 1'($urandom);
         @(negedge clk);
         chk("bp_hold", {ifc.cout, ifc.sum}, held);
         chk("bp_in_ready", 65'(ifc.in_ready), 65'd0);
      end
      a2 = rnd64();
      b2 = rnd64();
      c2 = 1'($urandom);
      ifc.in_a      = a2;
      ifc.in_b      = b2;
      ifc.cin       = c2;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
      chk("bp_idle_ready", 65'(ifc.in_ready), 65'd1);
      chk("bp_idle_valid", 65'(ifc.out_valid), 65'd0);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk("bp_accepted", 65'(ifc.in_ready), 65'd0);
      wait_done(1'b0, lat);
      chk("bp_second", {ifc.cout, ifc.sum}, ref_add(a2, b2, c2));
      $display("op backpressure a=%h b=%h cin=%0d -> cout=%0d sum=%h", a2, b2, c2, ifc.cout, ifc.sum);
      finish_op(2);

      // Reset in the middle of an addition.
      send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", 65'(ifc.in_ready), 65'd1);
      chk("mid_rst_valid", 65'(ifc.out_valid), 65'd0);
      chk("mid_rst_sum", {ifc.cout, ifc.sum}, 65'd0);
      $display("op mid-add reset -> in_ready=%0d out_valid=%0d sum=%h", ifc.in_ready, ifc.out_valid, ifc.sum);
      op_literal("after_rst", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 65'h1_0000_0001);

      for (int t = 0; t < 1000; t++) begin
         case ($urandom_range(0, 3))
            0: begin a = rnd64(); b = rnd64(); end
            1: begin a = 64'($urandom) * 64'($urandom); b = 64'($urandom) * 64'($urandom); end
            2: begin a = rnd64(); b = ~a; end
            default: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'($urandom_range(0, 2)); end
         endcase
         c = 1'($urandom);
         send(a, b, c);
         wait_done(1'b1, lat);
         chk("rand_lat", 65'(lat), 65'(N));
         chk("rand_result", {ifc.cout, ifc.sum}, ref_add(a, b, c));
         $display("op rand%0d a=%h b=%h cin=%0d -> cout=%0d sum=%h", t, a, b, c, ifc.cout, ifc.sum);
         finish_op($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
